// File: rtl/time_interval_log.sv
// Turns START/STOP commands into per-region elapsed-cycle records, queued in a show-ahead FIFO.
// Optional TIME_LOG_ERR_CNT_EN adds a saturating count of STOPs issued without a matching START.
module time_interval_log #(
  parameter int WIDTH = 64,
  parameter int ID_W  = 3,
  parameter int DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  curr_time,
  input  logic              ivalid,
  output logic              iready,
  input  logic [WIDTH-1:0]  command,
  output logic              ovalid,
  input  logic              oready,
  output logic [WIDTH-1:0]  result,
  output logic [ID_W-1:0]   result_id,
  output logic [15:0]       err_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int NID = 1 << ID_W;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_START = 2'b01,
    OP_STOP  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  op_t                    op;
  logic [ID_W-1:0]        cmd_id;
  logic                   unused_cmd_bits;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   clear;
  logic                   full;
  logic                   empty;
  logic [WIDTH-1:0]       elapsed;

  logic [NID-1:0]         armed;
  logic [WIDTH-1:0]       start_time [NID];
  logic [ID_W+WIDTH-1:0]  mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [ID_W+WIDTH-1:0]  head;
  logic [ID_W+WIDTH-1:0]  held_head;

  assign op              = op_t'(command[1:0]);
  assign cmd_id          = command[ID_W+1:2];
  assign unused_cmd_bits = ^command[WIDTH-1:ID_W+2];

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign iready = ~full & ~reset;
  assign ovalid = ~empty;

  assign accept  = ivalid & iready;
  assign push    = accept && (op == OP_STOP) && armed[cmd_id];
  assign clear   = accept && (op == OP_CLEAR);
  assign pop     = ovalid & oready;
  assign elapsed = curr_time - start_time[cmd_id];

  always_ff @(posedge clock) begin
    if (reset) begin
      armed <= '0;
    end else if (clear) begin
      armed <= '0;
    end else if (accept && (op == OP_START)) begin
      armed[cmd_id] <= 1'b1;
    end else if (push) begin
      armed[cmd_id] <= 1'b0;
    end
  end

  // Timestamps need no reset: an entry is only read while its armed bit is set.
  always_ff @(posedge clock) begin
    if (accept && (op == OP_START)) begin
      start_time[cmd_id] <= curr_time;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {cmd_id, elapsed};
    end
  end

  // A flush simply snaps the read pointer onto the write pointer, overriding any pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (clear) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  assign head = mem[rd_ptr[AW-1:0]];

  // Remember the last visible head so the outputs stay put once the FIFO drains or is flushed.
  always_ff @(posedge clock) begin
    if (reset) begin
      held_head <= '0;
    end else if (!empty) begin
      held_head <= head;
    end
  end

  always_comb begin
    result    = held_head[WIDTH-1:0];
    result_id = held_head[ID_W+WIDTH-1:WIDTH];
    if (!empty) begin
      result    = head[WIDTH-1:0];
      result_id = head[ID_W+WIDTH-1:WIDTH];
    end
  end

`ifdef TIME_LOG_ERR_CNT_EN
  logic        stray_stop;
  logic [15:0] err_q;

  assign stray_stop = accept && (op == OP_STOP) && !armed[cmd_id];

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= '0;
    end else if (stray_stop && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 16'h0;
`endif

endmodule

// File: tb/tb_time_interval_log.sv
// Directed bench for time_interval_log: hand-computed records, backpressure, CLEAR and reset.
module tb_time_interval_log;

  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
`ifdef TIME_LOG_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [63:0] curr_time;
  logic        ivalid;
  logic        iready;
  logic [63:0] command;
  logic        ovalid;
  logic        oready;
  logic [63:0] result;
  logic [2:0]  result_id;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  time_interval_log dut (
    .clock     (clock),
    .reset     (reset),
    .curr_time (curr_time),
    .ivalid    (ivalid),
    .iready    (iready),
    .command   (command),
    .ovalid    (ovalid),
    .oready    (oready),
    .result    (result),
    .result_id (result_id),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] mk(input logic [1:0] op, input logic [2:0] id);
    logic [63:0] c;
    c      = '0;
    c[1:0] = op;
    c[4:2] = id;
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the command was taken.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] id, input logic [63:0] t);
    int waited;
    waited    = 0;
    ivalid    = 1'b1;
    command   = mk(op, id);
    curr_time = t;
    while (!iready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("accept_timeout", 64'(waited < 50), 64'd1);
    @(posedge clock);
    @(negedge clock);
    ivalid  = 1'b0;
    command = '0;
  endtask

  task automatic popOne();
    oready = 1'b1;
    @(negedge clock);
    oready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    ivalid    = 1'b0;
    oready    = 1'b0;
    command   = '0;
    curr_time = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_ovalid", 64'(ovalid), 64'd0);
    checkOutput("rst_iready", 64'(iready), 64'd0);
    checkOutput("rst_result", result, 64'd0);
    checkOutput("rst_result_id", 64'(result_id), 64'd0);
    checkOutput("rst_err", 64'(err_count), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_rst_iready", 64'(iready), 64'd1);

    // Basic interval
    applyStimulus(OP_START, 3'd2, 64'd100);
    checkOutput("start_no_push", 64'(ovalid), 64'd0);
    applyStimulus(OP_STOP, 3'd2, 64'd250);
    checkOutput("t1_ovalid", 64'(ovalid), 64'd1);
    checkOutput("t1_result", result, 64'd150);
    checkOutput("t1_id", 64'(result_id), 64'd2);
    popOne();
    checkOutput("t1_pop_ovalid", 64'(ovalid), 64'd0);
    checkOutput("t1_hold_result", result, 64'd150);
    checkOutput("t1_hold_id", 64'(result_id), 64'd2);

    // Timer rollover
    applyStimulus(OP_START, 3'd1, 64'hFFFF_FFFF_FFFF_FFFB);
    applyStimulus(OP_STOP, 3'd1, 64'd10);
    checkOutput("wrap_result", result, 64'd15);
    checkOutput("wrap_id", 64'(result_id), 64'd1);
    popOne();

    // Unarmed STOP
    applyStimulus(OP_STOP, 3'd5, 64'd300);
    checkOutput("stray_ovalid", 64'(ovalid), 64'd0);
    checkOutput("stray_err", 64'(err_count), ERR_EN ? 64'd1 : 64'd0);

    // Fill the FIFO and hold a ninth command under backpressure
    for (int i = 0; i < 8; i++) applyStimulus(OP_START, 3'(i), 64'(1000 + i));
    for (int i = 0; i < 8; i++) applyStimulus(OP_STOP, 3'(i), 64'(2000 + 3 * i));
    checkOutput("full_iready", 64'(iready), 64'd0);
    checkOutput("full_ovalid", 64'(ovalid), 64'd1);
    checkOutput("full_head", result, 64'd1000);
    ivalid    = 1'b1;
    command   = mk(OP_START, 3'd6);
    curr_time = 64'd5000;
    repeat (3) @(negedge clock);
    checkOutput("held_iready", 64'(iready), 64'd0);
    checkOutput("held_head", result, 64'd1000);
    oready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_result", result, 64'(1000 + 2 * i));
      checkOutput("drain_id", 64'(result_id), 64'(i));
      if (i == 1) checkOutput("iready_after_pop", 64'(iready), 64'd1);
      if (i == 2) begin
        ivalid  = 1'b0;
        command = '0;
      end
      @(negedge clock);
    end
    oready = 1'b0;
    checkOutput("drained_ovalid", 64'(ovalid), 64'd0);
    applyStimulus(OP_STOP, 3'd6, 64'd5100);
    checkOutput("held_cmd_result", result, 64'd100);
    checkOutput("held_cmd_id", 64'(result_id), 64'd6);
    popOne();

    // CLEAR beats a simultaneous pop and disarms everything
    applyStimulus(OP_START, 3'd0, 64'd0);
    applyStimulus(OP_STOP, 3'd0, 64'd7);
    applyStimulus(OP_START, 3'd1, 64'd0);
    applyStimulus(OP_STOP, 3'd1, 64'd8);
    applyStimulus(OP_START, 3'd2, 64'd0);
    applyStimulus(OP_STOP, 3'd2, 64'd9);
    applyStimulus(OP_START, 3'd4, 64'd50);
    checkOutput("pre_clear_head", result, 64'd7);
    oready = 1'b1;
    applyStimulus(OP_CLEAR, 3'd0, 64'd60);
    oready = 1'b0;
    checkOutput("clear_ovalid", 64'(ovalid), 64'd0);
    checkOutput("clear_hold_result", result, 64'd7);
    checkOutput("clear_hold_id", 64'(result_id), 64'd0);
    applyStimulus(OP_STOP, 3'd4, 64'd99);
    checkOutput("clear_stop_ovalid", 64'(ovalid), 64'd0);
    checkOutput("clear_stop_err", 64'(err_count), ERR_EN ? 64'd2 : 64'd0);

    // Reset in mid-operation
    applyStimulus(OP_START, 3'd0, 64'd0);
    applyStimulus(OP_STOP, 3'd0, 64'd20);
    applyStimulus(OP_START, 3'd1, 64'd0);
    applyStimulus(OP_STOP, 3'd1, 64'd30);
    applyStimulus(OP_START, 3'd3, 64'd40);
    checkOutput("pre_rst_ovalid", 64'(ovalid), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst_ovalid", 64'(ovalid), 64'd0);
    checkOutput("midrst_iready", 64'(iready), 64'd0);
    checkOutput("midrst_result", result, 64'd0);
    checkOutput("midrst_err", 64'(err_count), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    applyStimulus(OP_STOP, 3'd3, 64'd90);
    checkOutput("rst_stop_ovalid", 64'(ovalid), 64'd0);
    checkOutput("rst_stop_err", 64'(err_count), ERR_EN ? 64'd1 : 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
